// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with thresholds, read strobe, sticky errors and full read/write pass
module fifo_sync_param #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_counter,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc;
  assign empty        = fifo_counter == '0;
  assign full         = fifo_counter == (ADDR_WIDTH+1)'(DEPTH);
  assign almost_empty = fifo_counter <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
  assign almost_full  = fifo_counter >= (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  assign rd_acc       = rd & ~empty;
  assign wr_acc       = wr & (~full | rd_acc);
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
      fifo_counter <= (wr_acc && !rd_acc) ? fifo_counter + 1'b1 :
                      (rd_acc && !wr_acc) ? fifo_counter - 1'b1 : fifo_counter;
      data_out     <= rd_acc ? mem[rd_ptr] : data_out;
      data_valid   <= rd_acc;
      overflow     <= (overflow & ~clr_err) | (wr & ~wr_acc);
      underflow    <= (underflow & ~clr_err) | (rd & empty);
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: randomized and directed checks of fifo_sync_param against a queue model
module tb_fifo_sync_param;
  logic        clk = 0, reset = 1, wr = 0, rd = 0, clr_err = 0;
  logic [31:0] data_in = 0, data_out;
  logic        data_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  fifo_counter;
  int n_tests = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] m_out = 0;
  logic        m_valid = 0, m_ovf = 0, m_unf = 0;

  fifo_sync_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr(wr), .rd(rd), .clr_err(clr_err),
    .data_out(data_out), .data_valid(data_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .fifo_counter(fifo_counter),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_out = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [31:0] d);
    int sz;
    bit ra, wa;
    wr = w; rd = r; clr_err = c; data_in = d;
    @(posedge clk);
    sz = q.size();
    ra = r && sz > 0;
    wa = w && (sz < 8 || ra);
    m_valid = ra;
    if (ra) m_out = q.pop_front();
    if (wa) q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wa);
    m_unf = (m_unf && !c) || (r && sz == 0);
    #1;
    wr = 0; rd = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    model_reset();
    #1;
    n_tests++; if (fifo_counter !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_counter); end
    n_tests++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got %b want 1100", {empty, almost_empty, full, almost_full}); end
    n_tests++; if ({data_out, data_valid, overflow, underflow} !== 35'd0) begin n_fail++; $display("FAIL reset_outputs got %h/%b%b%b want 0", data_out, data_valid, overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 32'h11 * (i + 1));
      n_tests++; if (fifo_counter !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, fifo_counter, i + 1); end
      n_tests++; if (almost_full !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_almost_full[%0d] got %b want %b", i, almost_full, i + 1 >= 6); end
      n_tests++; if (almost_empty !== (i + 1 <= 2)) begin n_fail++; $display("FAIL fill_almost_empty[%0d] got %b want %b", i, almost_empty, i + 1 <= 2); end
    end
    n_tests++; if ({full, empty, overflow} !== 3'b100) begin n_fail++; $display("FAIL fill_flags got %b want 100", {full, empty, overflow}); end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 32'h99);
    n_tests++; if ({overflow, fifo_counter} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL ovf_set got %b/%0d want 1/8", overflow, fifo_counter); end
    step(0, 0, 1, 0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    step(1, 0, 1, 32'h9A);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    step(0, 0, 1, 0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2 got %b want 0", overflow); end
  endtask

  task automatic test_full_rdwr();
    step(1, 1, 0, 32'hAA);
    n_tests++; if ({data_valid, data_out, fifo_counter, overflow} !== {1'b1, 32'h11, 4'd8, 1'b0}) begin n_fail++; $display("FAIL full_rdwr got v=%b d=%h c=%0d o=%b want v=1 d=11 c=8 o=0", data_valid, data_out, fifo_counter, overflow); end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      n_tests++; if ({data_valid, data_out} !== {1'b1, (i < 7) ? 32'h11 * (i + 2) : 32'hAA}) begin n_fail++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, data_valid, data_out, (i < 7) ? 32'h11 * (i + 2) : 32'hAA); end
    end
    n_tests++; if ({empty, fifo_counter} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL drain_empty got %b/%0d want 1/0", empty, fifo_counter); end
  endtask

  task automatic test_empty_rdwr();
    step(1, 1, 0, 32'h55);
    n_tests++; if ({underflow, data_valid, fifo_counter} !== {1'b1, 1'b0, 4'd1}) begin n_fail++; $display("FAIL empty_rdwr got u=%b v=%b c=%0d want u=1 v=0 c=1", underflow, data_valid, fifo_counter); end
    step(0, 1, 0, 0);
    n_tests++; if ({data_valid, data_out} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL empty_rdwr_read got v=%b d=%h want v=1 d=55", data_valid, data_out); end
    step(0, 0, 1, 0);
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", underflow); end
  endtask

  task automatic test_stream();
    logic [31:0] sent[$];
    int got = 0;
    for (int i = 0; i <= 20; i++) begin
      logic [31:0] d = $urandom;
      if (i < 20) sent.push_back(d);
      step(i < 20, i > 0, 0, d);
      if (i > 0) begin
        n_tests++; if ({data_valid, data_out} !== {1'b1, sent[got]}) begin n_fail++; $display("FAIL stream[%0d] got v=%b d=%h want v=1 d=%h", got, data_valid, data_out, sent[got]); end
        got++;
      end
      n_tests++; if (fifo_counter > 4'd1 || overflow || underflow) begin n_fail++; $display("FAIL stream_state[%0d] got c=%0d o=%b u=%b want c<=1 o=0 u=0", i, fifo_counter, overflow, underflow); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'hE0 + i);
    n_tests++; if (fifo_counter !== 4'd5) begin n_fail++; $display("FAIL pre_reset_count got %0d want 5", fifo_counter); end
    step(0, 1, 0, 0);
    step(1, 0, 0, 32'hE5);
    @(negedge clk);
    #1 reset = 1;
    #1;
    n_tests++; if ({fifo_counter, empty, data_valid, data_out} !== {4'd0, 1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL async_reset got c=%0d e=%b v=%b d=%h want c=0 e=1 v=0 d=0", fifo_counter, empty, data_valid, data_out); end
    @(negedge clk);
    reset = 0;
    model_reset();
    step(1, 0, 0, 32'hC3);
    step(0, 1, 0, 0);
    n_tests++; if ({data_valid, data_out, empty} !== {1'b1, 32'hC3, 1'b1}) begin n_fail++; $display("FAIL post_reset_read got v=%b d=%h e=%b want v=1 d=c3 e=1", data_valid, data_out, empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8, $urandom);
      n_tests++; if (fifo_counter !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, fifo_counter, q.size()); end
      n_tests++; if ({empty, full, almost_empty, almost_full} !== {q.size() == 0, q.size() == 8, q.size() <= 2, q.size() >= 6}) begin n_fail++; $display("FAIL rnd_flags[%0d] got %b size %0d", i, {empty, full, almost_empty, almost_full}, q.size()); end
      n_tests++; if ({data_valid, data_out} !== {m_valid, m_out}) begin n_fail++; $display("FAIL rnd_data[%0d] got v=%b d=%h want v=%b d=%h", i, data_valid, data_out, m_valid, m_out); end
      n_tests++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL rnd_err[%0d] got %b%b want %b%b", i, overflow, underflow, m_ovf, m_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rdwr();
    test_empty_rdwr();
    test_stream();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
